// File: rtl/aes_pkg.sv
// Shared definitions for the AES-256 round-key sequencer.
//   state_e        : sequencer states (IDLE/EMIT/GEN/DONE)
//   SEL_*          : round-key mux select encodings
//   RCON_INIT      : first round constant
//   NR_AES256      : round count for AES-256
//   fb_sel()       : feedback-register select for a generated round
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GEN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SEL_MSBKEY = 2'b00;
  localparam logic [1:0] SEL_LSBKEY = 2'b01;
  localparam logic [1:0] SEL_FB_MSB = 2'b10;
  localparam logic [1:0] SEL_FB_LSB = 2'b11;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam int         NR_AES256 = 14;

  // Even rounds land in the MSB feedback register, odd rounds in the LSB one.
  function automatic logic [1:0] fb_sel(input logic odd);
    return odd ? SEL_FB_LSB : SEL_FB_MSB;
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register for the key generator.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (rcon -> RCON_INIT)
//   init      : reload RCON_INIT next cycle (wins over shift_en)
//   shift_en  : shift rcon left by one bit next cycle
//   rcon      : current round constant
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       shift_en,
  output logic [7:0] rcon
);

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  // A plain shift is enough: AES-256 never needs a constant past 8'h40,
  // so the GF(2^8) reduction after 8'h80 is never exercised.
  always_comb begin
    rcon_d = rcon_q;
    if (init) begin
      rcon_d = RCON_INIT;
    end else if (shift_en) begin
      rcon_d = rcon_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcon_q <= RCON_INIT;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon = rcon_q;

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 round-key sequencer. Steers the round-key mux, launches the key
// generator, loads the feedback registers and presents round keys 0..NR
// to the round datapath.
//
// Optional feature macro: KSCHED_ABORT_EN adds an 'abort' input that
// returns the sequencer to IDLE (reset output values, no done pulse).
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a schedule (only looked at in IDLE)
//   rk_ready     : round datapath accepts the presented key
//   abort        : (KSCHED_ABORT_EN only) cancel the running schedule
//   sel          : round-key mux select (see aes_pkg SEL_*)
//   rk_valid     : mux output is round key round_idx
//   round_idx    : index of presented / generated round key
//   kg_en        : one-cycle key-generator launch pulse
//   kg_mode      : 0 RotWord+SubWord+Rcon, 1 SubWord only
//   rcon         : round constant for the key generator
//   fb_load_msb  : load MSB feedback register from the key generator
//   fb_load_lsb  : load LSB feedback register from the key generator
//   busy         : schedule in progress
//   done         : one-cycle pulse after key NR is accepted
//
// Handshake: a key transfers on a rising clk edge where rk_valid && rk_ready.
// While rk_valid is high and rk_ready low, every output is held; rk_ready is
// ignored while rk_valid is low.
//
// All outputs are registered: next-cycle values are computed in always_comb
// from the current state and captured together in one always_ff.
module aes256_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = NR_AES256,
  parameter int KG_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rk_ready,
`ifdef KSCHED_ABORT_EN
  input  logic       abort,
`endif
  output logic [1:0] sel,
  output logic       rk_valid,
  output logic [3:0] round_idx,
  output logic       kg_en,
  output logic       kg_mode,
  output logic [7:0] rcon,
  output logic       fb_load_msb,
  output logic       fb_load_lsb,
  output logic       busy,
  output logic       done
);

  localparam int             CW       = (KG_LAT > 1) ? $clog2(KG_LAT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(KG_LAT - 1);
  localparam logic [3:0]     NR_IDX   = 4'(NR);

  state_e        state_q,    state_d;
  logic [3:0]    round_q,    round_d;
  logic [1:0]    sel_q,      sel_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic          rk_valid_q, rk_valid_d;
  logic          kg_en_q,    kg_en_d;
  logic          kg_mode_q,  kg_mode_d;
  logic          fb_msb_q,   fb_msb_d;
  logic          fb_lsb_q,   fb_lsb_d;
  logic          busy_q,     busy_d;
  logic          done_q,     done_d;

  logic          rcon_init;
  logic          rcon_shift;
  logic [3:0]    nxt_round;

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    rk_valid_d = 1'b0;
    kg_en_d    = 1'b0;
    kg_mode_d  = kg_mode_q;
    fb_msb_d   = 1'b0;
    fb_lsb_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rcon_init  = 1'b0;
    rcon_shift = 1'b0;
    nxt_round  = round_q + 4'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_EMIT;
          round_d    = 4'd0;
          sel_d      = SEL_MSBKEY;
          rk_valid_d = 1'b1;
          busy_d     = 1'b1;
          rcon_init  = 1'b1;
        end
      end

      ST_EMIT: begin
        rk_valid_d = 1'b1;
        if (rk_valid_q && rk_ready) begin
          if (round_q == 4'd0) begin
            // Keys 0 and 1 come straight from the cipher key halves.
            round_d = 4'd1;
            sel_d   = SEL_LSBKEY;
          end else if (round_q == NR_IDX) begin
            state_d    = ST_DONE;
            rk_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            state_d    = ST_GEN;
            round_d    = nxt_round;
            rk_valid_d = 1'b0;
            sel_d      = fb_sel(nxt_round[0]);
            kg_en_d    = 1'b1;
            kg_mode_d  = nxt_round[0];
            cnt_d      = '0;
            // With a single-cycle generator the launch and load share a cycle.
            if (KG_LAT == 1) begin
              fb_msb_d = ~nxt_round[0];
              fb_lsb_d = nxt_round[0];
            end
          end
        end
      end

      ST_GEN: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = ST_EMIT;
          rk_valid_d = 1'b1;
          // rcon advances once per RotWord round, after it has been consumed.
          rcon_shift = ~round_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CNT_LAST) begin
            fb_msb_d = ~round_q[0];
            fb_lsb_d = round_q[0];
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef KSCHED_ABORT_EN
    // Abort beats any handshake in the same cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      round_d    = 4'd0;
      sel_d      = SEL_MSBKEY;
      cnt_d      = '0;
      rk_valid_d = 1'b0;
      kg_en_d    = 1'b0;
      kg_mode_d  = 1'b0;
      fb_msb_d   = 1'b0;
      fb_lsb_d   = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      rcon_init  = 1'b1;
      rcon_shift = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      round_q    <= 4'd0;
      sel_q      <= SEL_MSBKEY;
      cnt_q      <= '0;
      rk_valid_q <= 1'b0;
      kg_en_q    <= 1'b0;
      kg_mode_q  <= 1'b0;
      fb_msb_q   <= 1'b0;
      fb_lsb_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      rk_valid_q <= rk_valid_d;
      kg_en_q    <= kg_en_d;
      kg_mode_q  <= kg_mode_d;
      fb_msb_q   <= fb_msb_d;
      fb_lsb_q   <= fb_lsb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  aes_rcon_gen u_rcon (
    .clk      (clk),
    .rst      (rst),
    .init     (rcon_init),
    .shift_en (rcon_shift),
    .rcon     (rcon)
  );

  assign sel         = sel_q;
  assign rk_valid    = rk_valid_q;
  assign round_idx   = round_q;
  assign kg_en       = kg_en_q;
  assign kg_mode     = kg_mode_q;
  assign fb_load_msb = fb_msb_q;
  assign fb_load_lsb = fb_lsb_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Bench for aes256_key_sched_ctrl: two instances (KG_LAT=1 and KG_LAT=3),
// a schedule-level reference model pushed into per-instance expected queues
// when a start is issued, and negedge monitors that pop and compare.
module tb_aes256_key_sched_ctrl;

  localparam int NR = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic       start     [2];
  logic       rk_ready  [2];
`ifdef KSCHED_ABORT_EN
  logic       abort     [2];
`endif
  logic [1:0] sel       [2];
  logic       rk_valid  [2];
  logic [3:0] round_idx [2];
  logic       kg_en     [2];
  logic       kg_mode   [2];
  logic [7:0] rcon      [2];
  logic       fb_msb    [2];
  logic       fb_lsb    [2];
  logic       busy      [2];
  logic       done      [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (schedule-level rules) ----------------
  function automatic logic [1:0] exp_sel(input int r);
    if (r == 0) return 2'b00;
    if (r == 1) return 2'b01;
    return (r % 2 == 1) ? 2'b11 : 2'b10;
  endfunction

  // rcon visible while key r is presented: doubles after each even GEN round.
  function automatic logic [7:0] emit_rcon(input int r);
    return (r < 2) ? 8'h01 : 8'(1 << (r / 2));
  endfunction

  // rcon visible at the kg_en of round r: even rounds 2..14 -> 01..40.
  function automatic logic [7:0] kg_rcon(input int r);
    return 8'(1 << ((r - 1) / 2));
  endfunction

  // ---------------- DUTs and monitors ----------------
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int LAT = (g == 0) ? 1 : 3;

    aes256_key_sched_ctrl #(.NR(NR), .KG_LAT(LAT)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start[g]),
      .rk_ready    (rk_ready[g]),
`ifdef KSCHED_ABORT_EN
      .abort       (abort[g]),
`endif
      .sel         (sel[g]),
      .rk_valid    (rk_valid[g]),
      .round_idx   (round_idx[g]),
      .kg_en       (kg_en[g]),
      .kg_mode     (kg_mode[g]),
      .rcon        (rcon[g]),
      .fb_load_msb (fb_msb[g]),
      .fb_load_lsb (fb_lsb[g]),
      .busy        (busy[g]),
      .done        (done[g])
    );

    logic [31:0] key_q[$];
    logic [31:0] kg_q[$];
    logic [31:0] fb_q[$];
    bit          model_idle = 1'b1;
    bit          key_open   = 1'b0;
    int          evt        = 0;
    int          kg_cyc     = 0;
    int          done_due   = -1;
    logic [3:0]  held_round = '0;
    logic [1:0]  held_sel   = '0;

    task automatic flush();
      key_q.delete();
      kg_q.delete();
      fb_q.delete();
      model_idle = 1'b1;
      key_open   = 1'b0;
      done_due   = -1;
    endtask

    always @(negedge clk) begin
      logic [31:0] e;
      bit          aborted;
      aborted = 1'b0;
`ifdef KSCHED_ABORT_EN
      aborted = abort[g] && !model_idle;
`endif
      if (rst || aborted) begin
        flush();
      end else begin
        if (start[g] && model_idle) begin
          for (int r = 0; r <= NR; r++) begin
            int lat;
            lat = (r < 2) ? 1 : 1 + LAT;
            key_q.push_back({10'b0, 8'(lat), 4'(r), exp_sel(r), emit_rcon(r)});
            if (r >= 2) begin
              kg_q.push_back({17'b0, 4'(r), 1'(r % 2), exp_sel(r), kg_rcon(r)});
              fb_q.push_back({26'b0, 4'(r), 1'(r % 2 == 0), 1'(r % 2)});
            end
          end
          model_idle = 1'b0;
          evt        = cyc;
        end

        if (rk_valid[g]) begin
          if (!key_open) begin
            if (key_q.size() == 0) begin
              check("key_unexpected", {28'b0, round_idx[g]}, 32'hFFFF_FFFF);
              held_round = round_idx[g];
              held_sel   = sel[g];
            end else begin
              e = key_q.pop_front();
              check("key_lat_idx_sel_rcon",
                    {10'b0, 8'(cyc - evt), round_idx[g], sel[g], rcon[g]}, e);
              check("key_busy", {31'b0, busy[g]}, 32'd1);
              held_round = e[13:10];
              held_sel   = e[9:8];
            end
            key_open = 1'b1;
          end else begin
            check("stall_stable", {26'b0, round_idx[g], sel[g]}, {26'b0, held_round, held_sel});
          end
          check("no_kg_while_valid", {30'b0, kg_en[g], fb_msb[g] | fb_lsb[g]}, 32'd0);
          if (rk_ready[g]) begin
            key_open = 1'b0;
            evt      = cyc;
            if (held_round == 4'(NR)) done_due = cyc + 1;
          end
        end

        if (kg_en[g]) begin
          if (kg_q.size() == 0) begin
            check("kg_unexpected", {28'b0, round_idx[g]}, 32'hFFFF_FFFF);
          end else begin
            e = kg_q.pop_front();
            check("kg_idx_mode_sel_rcon",
                  {17'b0, round_idx[g], kg_mode[g], sel[g], rcon[g]}, e);
            check("kg_lat", 32'(cyc - evt), 32'd1);
          end
          kg_cyc = cyc;
        end

        if (fb_msb[g] || fb_lsb[g]) begin
          if (fb_q.size() == 0) begin
            check("fb_unexpected", {28'b0, round_idx[g]}, 32'hFFFF_FFFF);
          end else begin
            e = fb_q.pop_front();
            check("fb_idx_msb_lsb", {26'b0, round_idx[g], fb_msb[g], fb_lsb[g]}, e);
            check("fb_gen_cycle", 32'(cyc - kg_cyc), 32'(LAT - 1));
          end
        end

        if (done[g]) begin
          check("done_cycle", 32'(cyc), 32'(done_due));
          check("done_busy", {31'b0, busy[g]}, 32'd0);
        end else if (cyc == done_due) begin
          check("done_missing", {31'b0, done[g]}, 32'd1);
        end
        if (cyc == done_due) model_idle = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input int g);
    check("rst_sel",      {30'b0, sel[g]},       32'd0);
    check("rst_rk_valid", {31'b0, rk_valid[g]},  32'd0);
    check("rst_round",    {28'b0, round_idx[g]}, 32'd0);
    check("rst_kg_en",    {31'b0, kg_en[g]},     32'd0);
    check("rst_kg_mode",  {31'b0, kg_mode[g]},   32'd0);
    check("rst_rcon",     {24'b0, rcon[g]},      32'h01);
    check("rst_fb",       {30'b0, fb_msb[g], fb_lsb[g]}, 32'd0);
    check("rst_busy",     {31'b0, busy[g]},      32'd0);
    check("rst_done",     {31'b0, done[g]},      32'd0);
  endtask

  // mode 0: ready high; 1: random ready; 2: 5-cycle stall at round 7;
  // 3: random ready plus stray start pulses mid-schedule.
  task automatic run_sched(input int g, input int mode);
    int  n;
    int  stall;
    bit  seen_done;
    tick();
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
    n = 0;
    stall = 0;
    seen_done = 1'b0;
    while (!seen_done && n < 2000) begin
      if (mode == 2 && rk_valid[g] && round_idx[g] == 4'd7 && stall < 5) begin
        rk_ready[g] = 1'b0;
        stall++;
      end else if (mode == 1 || mode == 3) begin
        rk_ready[g] = ($urandom_range(0, 3) != 0);
      end else begin
        rk_ready[g] = 1'b1;
      end
      if (mode == 3) start[g] = ($urandom_range(0, 5) == 0);
      tick();
      if (done[g]) begin
        seen_done = 1'b1;
        start[g]  = 1'b0;
      end
      n++;
    end
    start[g] = 1'b0;
    check("sched_done_seen", {31'b0, seen_done}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    for (int g = 0; g < 2; g++) begin
      start[g]    = 1'b0;
      rk_ready[g] = 1'b0;
`ifdef KSCHED_ABORT_EN
      abort[g]    = 1'b0;
`endif
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset(0);
    check_reset(1);

    run_sched(0, 0);
    run_sched(0, 2);
    for (int i = 0; i < 3; i++) run_sched(0, 1);
    for (int i = 0; i < 2; i++) run_sched(0, 3);

    // Reset while generating round 9.
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    rk_ready[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (kg_en[0] && round_idx[0] == 4'd9) found = 1'b1;
    end
    check("gen9_reached", {31'b0, found}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset(0);
    run_sched(0, 0);

    run_sched(1, 0);
    run_sched(1, 2);
    for (int i = 0; i < 2; i++) run_sched(1, 1);
    run_sched(1, 3);

`ifdef KSCHED_ABORT_EN
    tick();
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    rk_ready[1] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (rk_valid[1] && round_idx[1] == 4'd4) found = 1'b1;
      else tick();
    end
    check("emit4_reached", {31'b0, found}, 32'd1);
    abort[1] = 1'b1;
    tick();
    abort[1] = 1'b0;
    check("abort_busy",     {31'b0, busy[1]},      32'd0);
    check("abort_rk_valid", {31'b0, rk_valid[1]},  32'd0);
    check("abort_done",     {31'b0, done[1]},      32'd0);
    check("abort_rcon",     {24'b0, rcon[1]},      32'h01);
    check("abort_round",    {28'b0, round_idx[1]}, 32'd0);
    repeat (6) tick();
    run_sched(1, 0);
`endif

    repeat (8) tick();
    check("left_key0", 32'(mon[0].key_q.size()), 32'd0);
    check("left_kg0",  32'(mon[0].kg_q.size()),  32'd0);
    check("left_fb0",  32'(mon[0].fb_q.size()),  32'd0);
    check("left_key1", 32'(mon[1].key_q.size()), 32'd0);
    check("left_kg1",  32'(mon[1].kg_q.size()),  32'd0);
    check("left_fb1",  32'(mon[1].fb_q.size()),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
